// File: rtl/abm_burst_writer.sv
// ----------------------------------------------------------------------------
// abm_burst_writer
//   AXI4 INCR burst write master feeding one slave port of the ABM AXI4-MM
//   mux. A job (start address, beat count) is split into bursts of at most
//   MAX_BURST beats that never cross a 4 KB boundary. Write data is taken
//   straight from an AXI-Stream input, in order.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   start, addr, beats     job request (start is a one-cycle pulse, idle only)
//   busy, done, error      job status (done is a one-cycle pulse, error sticky)
//   AXIS_RX_*              write data stream in
//   M_AXI_AW*              write address channel
//   M_AXI_W*               write data channel
//   M_AXI_B*               write response channel
// ----------------------------------------------------------------------------
module abm_burst_writer #(
    parameter int unsigned DW              = 512,
    parameter int unsigned AW              = 64,
    parameter int unsigned MAX_BURST       = 64,
    parameter int unsigned MAX_OUTSTANDING = 255
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [AW-1:0]   addr,
    input  logic [31:0]     beats,
    output logic            busy,
    output logic            done,
    output logic            error,
    input  logic [DW-1:0]   AXIS_RX_TDATA,
    input  logic            AXIS_RX_TVALID,
    output logic            AXIS_RX_TREADY,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [3:0]      M_AXI_AWID,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWLOCK,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [3:0]      M_AXI_AWQOS,
    output logic [2:0]      M_AXI_AWPROT,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WVALID,
    output logic            M_AXI_WLAST,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);

    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  cur_addr_q, cur_addr_d;
    logic [31:0]    remaining_q, remaining_d;
    logic [8:0]     len_q, len_d;
    logic [7:0]     beat_q, beat_d;
    logic [7:0]     outs_q, outs_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;

    logic [31:0]    room_beats;
    logic [31:0]    len_cand;
    logic [8:0]     burst_len;
    logic           aw_hs, w_hs, b_hs, b_count;

    // Burst length: limited by remaining beats, MAX_BURST and the distance
    // to the next 4 KB boundary (cur_addr is always beat aligned).
    always_comb begin
        room_beats = 32'(13'h1000 - {1'b0, cur_addr_q[11:0]}) >> SIZE;
        len_cand   = remaining_q;
        if (len_cand > MAX_BURST) begin
            len_cand = MAX_BURST;
        end
        if (len_cand > room_beats) begin
            len_cand = room_beats;
        end
        burst_len = 9'(len_cand);
    end

    // AW channel
    assign M_AXI_AWVALID = (state_q == S_ADDR) && (32'(outs_q) < MAX_OUTSTANDING);
    assign M_AXI_AWADDR  = cur_addr_q;
    assign M_AXI_AWLEN   = 8'(burst_len - 9'd1);
    assign M_AXI_AWSIZE  = 3'(SIZE);
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWPROT  = '0;

    // W channel: the stream is coupled to W only while in DATA
    assign M_AXI_WDATA    = AXIS_RX_TDATA;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WVALID   = (state_q == S_DATA) && AXIS_RX_TVALID;
    assign AXIS_RX_TREADY = (state_q == S_DATA) && M_AXI_WREADY;
    assign M_AXI_WLAST    = (state_q == S_DATA) && (beat_q == 8'(len_q - 9'd1));

    // B channel and status
    assign M_AXI_BREADY = busy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs    = M_AXI_BVALID && M_AXI_BREADY;
    // A response with nothing outstanding is accepted but not counted.
    assign b_count = b_hs && (outs_q != '0);

    always_comb begin
        outs_d = outs_q;
        case ({aw_hs, b_count})
            2'b10:   outs_d = outs_q + 8'd1;
            2'b01:   outs_d = outs_q - 8'd1;
            default: outs_d = outs_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        beat_d      = beat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q | (b_hs && (M_AXI_BRESP != 2'b00));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = addr;
                    remaining_d = beats;
                    beat_d      = '0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (beats == '0) ? S_FINISH : S_ADDR;
                end
            end
            S_ADDR: begin
                if (aw_hs) begin
                    len_d       = burst_len;
                    cur_addr_d  = cur_addr_q + (AW'(burst_len) << SIZE);
                    remaining_d = remaining_q - 32'(burst_len);
                    beat_d      = '0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (M_AXI_WLAST) begin
                        beat_d  = '0;
                        state_d = (remaining_q != '0) ? S_ADDR : S_DRAIN;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (outs_q == '0) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            outs_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            outs_q      <= outs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_abm_burst_writer.sv
// ----------------------------------------------------------------------------
// tb_abm_burst_writer
//   Self-checking bench for abm_burst_writer: a throttling AXI slave with a
//   byte-addressed memory, an incrementing-pattern stream source, a table of
//   jobs plus random jobs checked against a burst-split reference model, and
//   hand-written sequences for the zero-length job and mid-job reset.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_abm_burst_writer;

    localparam int unsigned DW    = 512;
    localparam int unsigned AW    = 64;
    localparam int unsigned MB    = 64;
    localparam int unsigned MO    = 2;
    localparam int unsigned BYTES = DW / 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [31:0]     beats = '0;
    logic            busy, done, error;
    logic [DW-1:0]   tdata = '0;
    logic            tvalid = 1'b0;
    logic            tready;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [3:0]      awid;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [3:0]      awqos;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [DW-1:0]   wdata;
    logic [BYTES-1:0] wstrb;
    logic            wvalid, wlast;
    logic            wready = 1'b0;
    logic [1:0]      bresp = 2'b00;
    logic            bvalid = 1'b0;
    logic            bready;

    abm_burst_writer #(
        .DW(DW), .AW(AW), .MAX_BURST(MB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .addr(addr), .beats(beats),
        .busy(busy), .done(done), .error(error),
        .AXIS_RX_TDATA(tdata), .AXIS_RX_TVALID(tvalid), .AXIS_RX_TREADY(tready),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWID(awid), .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock),
        .M_AXI_AWCACHE(awcache), .M_AXI_AWQOS(awqos), .M_AXI_AWPROT(awprot),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WLAST(wlast), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // slave / stream knobs
    int p_tv = 100, p_aw = 100, p_w = 100, b_dly = 0, err_burst = -1;

    // stream source and handshake flags (captured at negedge)
    int unsigned s_idx = 0;
    bit t_hs_l = 1'b0, b_hs_l = 1'b0;

    // slave state
    longint unsigned awq_addr[$];
    int unsigned     awq_len[$];
    int unsigned     w_off = 0;
    int              burst_idx = 0;
    int              bq_dly[$];
    logic [1:0]      bq_resp[$];
    logic [DW-1:0]   mem [longint unsigned];

    // observations
    longint unsigned obs_addr[$];
    int unsigned     obs_len[$];
    int unsigned     w_cnt = 0, done_cnt = 0, out_model = 0;
    bit              aw_pend = 1'b0;
    logic [AW-1:0]   pend_addr;
    logic [7:0]      pend_len;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] pat(input int unsigned i);
        logic [31:0] w;
        w = i * 32'h9E37_79B1 + 32'h1234_5678;
        return {8{w, ~w}};
    endfunction

    // Monitor / slave write side: sampled mid-cycle, describes the handshakes
    // that complete at the next rising edge.
    always @(negedge clk) begin
        if (!resetn) begin
            aw_pend = 1'b0;
            t_hs_l  = 1'b0;
            b_hs_l  = 1'b0;
        end else begin
            if (aw_pend) begin
                chk("aw_hold_valid", awvalid, 1);
                chk("aw_hold_addr", awaddr, pend_addr);
                chk("aw_hold_len", awlen, pend_len);
            end
            aw_pend   = awvalid && !awready;
            pend_addr = awaddr;
            pend_len  = awlen;
            chk("axis_w_lockstep", tvalid && tready, wvalid && wready);
            if (awvalid && awready) begin
                chk("aw_outstanding_limit", out_model < MO, 1);
                chk("aw_const", {awsize, awburst, awid, awlock, awcache, awqos, awprot},
                    {3'd6, 2'b01, 4'd0, 1'b0, 4'b0011, 4'd0, 3'd0});
                obs_addr.push_back(awaddr);
                obs_len.push_back(awlen);
                awq_addr.push_back(awaddr);
                awq_len.push_back(awlen);
                out_model++;
            end
            if (wvalid && wready) begin
                if (awq_addr.size() == 0) begin
                    chk("w_without_aw", 0, 1);
                end else begin
                    mem[awq_addr[0] + w_off * BYTES] = wdata;
                    chk("wlast", wlast, w_off == awq_len[0]);
                    chk("wstrb", wstrb, {BYTES{1'b1}});
                    if (w_off == awq_len[0]) begin
                        void'(awq_addr.pop_front());
                        void'(awq_len.pop_front());
                        w_off = 0;
                        bq_dly.push_back($urandom_range(b_dly, 0));
                        bq_resp.push_back((burst_idx == err_burst) ? 2'b10 : 2'b00);
                        burst_idx++;
                    end else begin
                        w_off++;
                    end
                end
                w_cnt++;
            end
            if (bvalid && bready && out_model > 0) out_model--;
            if (done) done_cnt++;
            t_hs_l = tvalid && tready;
            b_hs_l = bvalid && bready;
        end
    end

    // Drivers: stream source, ready throttling, delayed B responses.
    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            tvalid  = 1'b0;
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
            bresp   = 2'b00;
            bq_dly.delete();
            bq_resp.delete();
        end else begin
            if (t_hs_l) s_idx++;
            if (!(tvalid && !t_hs_l)) tvalid = ($urandom_range(99) < p_tv);
            tdata   = pat(s_idx);
            awready = ($urandom_range(99) < p_aw);
            wready  = ($urandom_range(99) < p_w);
            if (bvalid && b_hs_l) begin
                bvalid = 1'b0;
                void'(bq_dly.pop_front());
                void'(bq_resp.pop_front());
            end
            foreach (bq_dly[k]) if (bq_dly[k] > 0) bq_dly[k] = bq_dly[k] - 1;
            if (!bvalid && bq_dly.size() > 0 && bq_dly[0] == 0) begin
                bvalid = 1'b1;
                bresp  = bq_resp[0];
            end
        end
    end

    task automatic set_knobs(input int ptv, input int paw, input int pw, input int bd, input int eb);
        p_tv = ptv; p_aw = paw; p_w = pw; b_dly = bd; err_burst = eb;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_len.delete();
        w_cnt = 0; done_cnt = 0; burst_idx = 0;
        mem.delete();
    endtask

    // exp_nb / exp_err < 0: take the expectation from the reference model only
    task automatic run_job(input string tag, input longint unsigned a, input int unsigned n,
                           input int eb, input int exp_nb, input int exp_err,
                           input int ptv, input int paw, input int pw, input int bd);
        longint unsigned m_addr[$];
        int unsigned     m_len[$];
        longint unsigned ca;
        int unsigned     rem, room, l, base;
        int              e_err;
        logic [DW-1:0]   got;
        longint unsigned key;

        // reference: split the job by the three limits
        ca  = a;
        rem = n;
        while (rem > 0) begin
            room = (4096 - int'(ca % 4096)) / BYTES;
            l = rem;
            if (l > MB) l = MB;
            if (l > room) l = room;
            m_addr.push_back(ca);
            m_len.push_back(l);
            ca  += l * BYTES;
            rem -= l;
        end
        e_err = (exp_err >= 0) ? exp_err : int'((eb >= 0) && (eb < m_addr.size()));

        set_knobs(ptv, paw, pw, bd, eb);
        clear_obs();
        base = s_idx;

        @(posedge clk); #2;
        start = 1'b1; addr = a; beats = n;
        @(posedge clk); #2;
        start = 1'b0;
        chk({tag, ":busy_on_start"}, busy, 1);
        chk({tag, ":error_cleared"}, error, 0);

        for (int c = 0; c < 5000; c++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) break;
        end
        chk({tag, ":done_seen"}, done_cnt > 0, 1);
        chk({tag, ":busy_at_done"}, busy, 0);
        chk({tag, ":error_at_done"}, error, e_err[0]);
        chk({tag, ":all_b_before_done"}, out_model, 0);
        if (exp_nb >= 0) chk({tag, ":bursts_table"}, obs_addr.size(), exp_nb);
        chk({tag, ":bursts_model"}, obs_addr.size(), m_addr.size());
        for (int i = 0; i < m_addr.size() && i < obs_addr.size(); i++) begin
            chk({tag, ":aw_addr"}, obs_addr[i], m_addr[i]);
            chk({tag, ":aw_len"}, obs_len[i], m_len[i] - 1);
        end
        chk({tag, ":w_beats"}, w_cnt, n);
        for (int unsigned j = 0; j < n; j++) begin
            key = a + j * BYTES;
            got = mem.exists(key) ? mem[key] : '0;
            chk({tag, ":mem_data"}, got, pat(base + j));
        end
        repeat (5) @(negedge clk);
        #1;
        chk({tag, ":done_once"}, done_cnt, 1);
        chk({tag, ":error_sticky"}, error, e_err[0]);
    endtask

    typedef struct {
        longint unsigned a;
        int unsigned     n;
        int              eb;
        int              nb;
        int              err;
        int              ptv, paw, pw, bd;
    } job_t;

    job_t jobs[8];

    initial begin
        jobs[0] = '{64'h1000,   10, -1, 1, 0, 100, 100, 100, 0};
        jobs[1] = '{64'h0FC0,    3, -1, 2, 0, 100, 100, 100, 0};
        jobs[2] = '{64'h0000,  200, -1, 4, 0, 100, 100, 100, 2};
        jobs[3] = '{64'h0000,  200,  1, 4, 1, 100, 100, 100, 2};
        jobs[4] = '{64'h2000,    5, -1, 1, 0, 100, 100, 100, 0};
        jobs[5] = '{64'h5F00,  130, -1, 3, 0,  50,  40,  50, 8};
        jobs[6] = '{64'h1FFC0,   1,  0, 1, 1, 100, 100, 100, 0};
        jobs[7] = '{64'h3FC0,   70, -1, 3, 0,  60,  70,  60, 4};

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("reset:outputs", {busy, done, error, awvalid, wvalid, wlast, bready, tready}, 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        foreach (jobs[i]) begin
            run_job($sformatf("job%0d", i), jobs[i].a, jobs[i].n, jobs[i].eb, jobs[i].nb,
                    jobs[i].err, jobs[i].ptv, jobs[i].paw, jobs[i].pw, jobs[i].bd);
        end

        for (int r = 0; r < 4; r++) begin
            run_job($sformatf("rand%0d", r),
                    longint'($urandom_range(1023, 0)) * BYTES,
                    $urandom_range(150, 1),
                    ($urandom_range(2, 0) == 0) ? int'($urandom_range(2, 0)) : -1,
                    -1, -1,
                    $urandom_range(100, 30), $urandom_range(100, 30),
                    $urandom_range(100, 30), $urandom_range(6, 0));
        end

        // zero-length job: done two cycles after start, nothing on AW/W
        set_knobs(100, 100, 100, 0, -1);
        clear_obs();
        @(posedge clk); #2;
        start = 1'b1; addr = 64'h40; beats = 0;
        @(posedge clk); #2;
        start = 1'b0;
        chk("zero:busy", busy, 1);
        chk("zero:done_early", done, 0);
        @(posedge clk); #2;
        chk("zero:done", done, 1);
        chk("zero:busy_clear", busy, 0);
        @(posedge clk); #2;
        chk("zero:done_pulse", done, 0);
        chk("zero:no_aw", obs_addr.size(), 0);
        chk("zero:no_w", w_cnt, 0);

        // reset in the middle of a long job
        set_knobs(70, 80, 70, 3, -1);
        clear_obs();
        @(posedge clk); #2;
        start = 1'b1; addr = 64'h0; beats = 200;
        @(posedge clk); #2;
        start = 1'b0;
        for (int c = 0; c < 5000 && w_cnt < 20; c++) @(negedge clk);
        chk("rst:progress", w_cnt >= 20, 1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("rst:outputs", {busy, done, error, awvalid, wvalid, wlast, bready, tready}, 0);
        awq_addr.delete();
        awq_len.delete();
        w_off = 0;
        out_model = 0;
        repeat (3) @(posedge clk);
        #2;
        w_cnt = 0;
        done_cnt = 0;
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("rst:no_done", done_cnt, 0);
        chk("rst:no_w", w_cnt, 0);
        chk("rst:idle", busy, 0);

        run_job("recover", 64'h7F80, 40, -1, 2, 0, 80, 80, 80, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/abm_burst_writer.md
Name: abm_burst_writer

Overview:
AXI4 burst write master that drives one slave port (S0 or S1) of the two-input AXI4-MM mux in the ABM manager.
- Accepts a write job (start address, beat count) and streams data from an AXI-Stream input into memory as INCR bursts.
- Splits each job so that no burst exceeds MAX_BURST beats or crosses a 4 KB boundary.
- Reports busy, done and sticky write-response error status to the controlling logic.

Parameters:
DW, 512, data width in bits (AXI W and AXIS TDATA); power of 2, 32..1024
AW, 64, AXI address width
MAX_BURST, 64, maximum beats per burst; 1..256, and MAX_BURST*(DW/8) <= 4096
MAX_OUTSTANDING, 255, maximum bursts awaiting a B response; 1..255

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches addr/beats when idle
addr  in  AW  job start address; must be aligned to DW/8
beats  in  32  job length in DW-wide beats
busy  out  1  high from accepted start until the last B is received
done  out  1  one-cycle pulse when a job completes
error  out  1  sticky; set when any BRESP != 0 during the job
AXIS_RX_TDATA  in  DW  write data stream
AXIS_RX_TVALID  in  1  stream valid
AXIS_RX_TREADY  out  1  stream ready
M_AXI_AWADDR/AWLEN/AWSIZE/AWID/AWBURST/AWLOCK/AWCACHE/AWQOS/AWPROT  out  AW/8/3/4/2/1/4/4/3  AW channel
M_AXI_AWVALID  out  1  AW valid
M_AXI_AWREADY  in  1  AW ready
M_AXI_WDATA  out  DW  write data
M_AXI_WSTRB  out  DW/8  write strobes
M_AXI_WVALID  out  1  W valid
M_AXI_WLAST  out  1  last beat of the burst
M_AXI_WREADY  in  1  W ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  B valid
M_AXI_BREADY  out  1  B ready; held at 1 while busy
(The read channel is not present on this block; the mux slave-port AR/R inputs are tied off at integration.)

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, error, AWVALID, WVALID, WLAST, BREADY, AXIS_RX_TREADY = 0; all counters = 0.
- Reset asserted mid-job aborts the job immediately. No done pulse is generated and no W beats are completed afterwards.
- Constant AW fields:
  - AWSIZE = log2(DW/8), AWBURST = 2'b01, AWID = 0, AWLOCK = 0
  - AWCACHE = 4'b0011, AWQOS = 0, AWPROT = 0
- WSTRB is all ones. WDATA = AXIS_RX_TDATA (combinational pass-through).
- Burst length rule, computed at each burst start:
  - bb = (4096 - cur_addr[11:0]) / (DW/8)
  - len = min(remaining, MAX_BURST, bb)
  - AWLEN = len - 1
  - Afterwards: cur_addr += len*(DW/8); remaining -= len
- State machine:
  - IDLE: start=1 latches addr/beats, clears error, sets busy.
    - beats == 0: go to FINISH.
    - otherwise: go to ADDR.
    - start while busy is ignored.
  - ADDR: if outstanding < MAX_OUTSTANDING, assert AWVALID with AWADDR/AWLEN stable until AWREADY; then go to DATA. AWVALID never drops before the handshake.
  - DATA:
    - WVALID = TVALID; TREADY = WREADY (both gated to this state only).
    - Beat counter counts W handshakes; WLAST = 1 when the count equals len-1.
    - On the WLAST handshake: remaining > 0 → go to ADDR; otherwise → go to DRAIN.
  - DRAIN: wait until outstanding == 0, then go to FINISH.
  - FINISH: done = 1 for one cycle, busy = 0, go to IDLE.
- Outstanding counter:
  - +1 on the AW handshake, -1 on the B handshake. Simultaneous events leave the count unchanged.
  - Never underflows. A BVALID seen with outstanding == 0 is ignored for counting but still accepted.
- error: set on any B handshake with BRESP != 0. Cleared only by an accepted start or by reset.
- The AXIS stream is never consumed outside DATA. Data order is preserved exactly.

Test Plan:
- DW=512, addr=0x1000, beats=10, zero-wait slave → one AW with AWLEN=9 and AWADDR=0x1000; 10 W beats with WLAST on the 10th; done pulses once after BVALID; error=0.
- addr=0x0FC0, beats=3 → AW0 at 0x0FC0 with AWLEN=0; AW1 at 0x1000 with AWLEN=1; 3 W beats total, WLAST on beats 1 and 3.
- addr=0, beats=200 → four bursts with AWLEN=63,63,63,7 at 0x0, 0x1000, 0x2000, 0x3000; done only after 4 B responses.
- Second burst returns BRESP=2'b10 → error=1 at done and stays 1; the next start clears it to 0.
- Random TVALID and WREADY throttling, plus delayed AWREADY/BVALID, beats=130 → memory model matches the incrementing input pattern; no beat lost or duplicated; AWVALID stable until handshake.
- beats=0 → done pulses 2 cycles after start with no AWVALID/WVALID. Separately, resetn low mid-burst → all outputs 0 immediately and no done pulse.
